memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-master arbiter in front of the shared single-port matrix memory. The host loader/configurator and the coprocessor `processor` each raise a request and wait for a grant. Only the granted master's address, data and enables reach the memory. Read data fans out from memory to both masters unmodified. The arbiter is the grant-side responder of the coprocessor's `out_request`/`in_grant` handshake.

## Interface
- `width`, 128: memory word width (`cell_width * size`).
- `memory_size_log`, 8: memory address width.
- `max_hold`, 1024: watchdog hold limit in cycles (used only with `ARB_WATCHDOG_EN`).

- `in_clk`  in  1  clock; all state updates on the rising edge.
- `in_reset`  in  1  asynchronous active-low reset.
- `in_host_request`  in  1  host requests memory ownership.
- `out_host_grant`  out  1  host owns memory.
- `in_host_mem_write_en`, `in_host_mem_read_en`  in  1 each  host memory enables.
- `in_host_mem_address`  in  `memory_size_log`  host address.
- `in_host_mem_data`  in  `width`  host write data.
- `in_cop_request`  in  1  coprocessor request (from `out_request`).
- `out_cop_grant`  out  1  coprocessor grant (to `in_grant`).
- `in_cop_mem_write_en`, `in_cop_mem_read_en`  in  1 each  coprocessor memory enables.
- `in_cop_mem_address`  in  `memory_size_log`  coprocessor address.
- `in_cop_mem_data`  in  `width`  coprocessor write data.
- `out_mem_write_en`, `out_mem_read_en`  out  1 each  memory enables.
- `out_mem_address`  out  `memory_size_log`  memory address.
- `out_mem_data`  out  `width`  memory write data.
- `out_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states:
  - IDLE: no grant.
  - HOST: `out_host_grant`=1.
  - COP: `out_cop_grant`=1.
  - TURN: one-cycle bus turnaround, no grant.
- One register `last` records the most recently served master. Reset value is COP, so the host wins the first contention.
- Transitions:
  - From IDLE, exactly one request: go to that master's state.
  - From IDLE, both requests: grant the master that is not `last`.
  - From IDLE, no request: stay in IDLE.
  - HOST/COP: hold while the owner's request stays high. Ownership is never preempted.
  - HOST/COP, owner's request sampled low: go to TURN and update `last`.
  - TURN: always go to IDLE. Requests are evaluated again in IDLE.
- Memory mux is combinational and selected by the registered state:
  - HOST: host address, data and enables drive the memory.
  - COP: coprocessor address, data and enables drive the memory.
  - IDLE/TURN: both enables are forced to 0; address and data are forced to 0.
- The ungranted master's enables are ignored. No error is raised for them.
- Read data path is outside this block; memory `out_data` connects to both masters directly.
- A request withdrawn before its grant is simply dropped. Nothing is queued.
- When write_en and read_en are both high from the owner, both pass through unchanged. Write/read priority is resolved by the memory.

## Timing
- Reset (async, `in_reset`=0):
  - state=IDLE, `last`=COP.
  - Both grants 0.
  - All `out_mem_*` outputs 0.
  - `out_timeout`=0.
- Reset asserted mid-ownership drops the grant and the memory enables immediately, without waiting for a clock edge.
- Grant latency:
  - Request sampled high at edge k (state IDLE) gives grant high after edge k.
  - The master may drive enables in the cycle after it sees the grant.
- Release:
  - Request sampled low at edge k gives grant low after edge k (TURN).
  - IDLE follows after edge k+1.
  - The earliest next grant is after edge k+2.
- Minimum ownership is 1 cycle. Back-to-back handover costs exactly 2 idle cycles.
- The arbiter never asserts both grants in the same cycle.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - A hold counter clears on every grant and increments each cycle in HOST/COP.
  - The counter saturates at `max_hold`. Its width is `$clog2(max_hold+1)`.
  - `out_timeout` sets when the counter equals `max_hold` while the non-owner's request is high.
  - `out_timeout` is sticky and is cleared only by reset.
  - The watchdog is observational only; the grant is not revoked.
- `ARB_WATCHDOG_EN` undefined:
  - No counter is built.
  - `out_timeout` is constant 0.
  - `max_hold` is unused.

## Test plan
- Reset, then host request at cycle 2 → host grant at cycle 3. Host writes address 0x04, data 0x…0001, and `out_mem_*` mirror it. Request drops at cycle 6 → grant low at cycle 7, memory enables 0 in cycles 7–8.
- Both requests rise in the same cycle after reset → host granted first. Host releases → coprocessor granted exactly 2 cycles after the host grant falls.
- Coprocessor owns the bus; host asserts `in_host_mem_write_en` to address 0x10 → `out_mem_write_en` follows the coprocessor only. Memory location 0x10 is unchanged.
- Coprocessor holds the grant for 20 cycles while the host keeps requesting → no preemption. Host grant arrives 2 cycles after the coprocessor releases.
- Reset pulled low during a coprocessor write → `out_cop_grant` and `out_mem_write_en` go to 0 asynchronously. After release of reset, state is IDLE and a simultaneous request pair grants the host.
- With `ARB_WATCHDOG_EN` and `max_hold`=8: host holds for 10 cycles while the coprocessor requests → `out_timeout` rises after 8 cycles of ownership and stays 1 after release, until reset.

Source files
------------

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-master arbiter for the shared single-port matrix memory
// Optional hold watchdog is built when ARB_WATCHDOG_EN is defined.
module memory_arbiter #(
  parameter int width           = 128,
  parameter int memory_size_log = 8,
  parameter int max_hold        = 1024
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_host_request,
  output logic                       out_host_grant,
  input  logic                       in_host_mem_write_en,
  input  logic                       in_host_mem_read_en,
  input  logic [memory_size_log-1:0] in_host_mem_address,
  input  logic [width-1:0]           in_host_mem_data,
  input  logic                       in_cop_request,
  output logic                       out_cop_grant,
  input  logic                       in_cop_mem_write_en,
  input  logic                       in_cop_mem_read_en,
  input  logic [memory_size_log-1:0] in_cop_mem_address,
  input  logic [width-1:0]           in_cop_mem_data,
  output logic                       out_mem_write_en,
  output logic                       out_mem_read_en,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic [width-1:0]           out_mem_data,
  output logic                       out_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOST = 2'd1;
  localparam logic [1:0] ST_COP  = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  logic [1:0] state, state_next;
  logic       last_cop, last_cop_next;  // 1: coprocessor was served most recently

  always_comb begin
    state_next    = state;
    last_cop_next = last_cop;
    case (state)
      ST_IDLE: begin
        if (in_host_request && in_cop_request) state_next = last_cop ? ST_HOST : ST_COP;
        else if (in_host_request)              state_next = ST_HOST;
        else if (in_cop_request)               state_next = ST_COP;
      end
      ST_HOST: begin
        if (!in_host_request) begin
          state_next    = ST_TURN;
          last_cop_next = 1'b0;
        end
      end
      ST_COP: begin
        if (!in_cop_request) begin
          state_next    = ST_TURN;
          last_cop_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state    <= ST_IDLE;
      last_cop <= 1'b1;
    end else begin
      state    <= state_next;
      last_cop <= last_cop_next;
    end
  end

  assign out_host_grant = (state == ST_HOST);
  assign out_cop_grant  = (state == ST_COP);

  always_comb begin
    out_mem_write_en = 1'b0;
    out_mem_read_en  = 1'b0;
    out_mem_address  = '0;
    out_mem_data     = '0;
    if (state == ST_HOST) begin
      out_mem_write_en = in_host_mem_write_en;
      out_mem_read_en  = in_host_mem_read_en;
      out_mem_address  = in_host_mem_address;
      out_mem_data     = in_host_mem_data;
    end else if (state == ST_COP) begin
      out_mem_write_en = in_cop_mem_write_en;
      out_mem_read_en  = in_cop_mem_read_en;
      out_mem_address  = in_cop_mem_address;
      out_mem_data     = in_cop_mem_data;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int              cnt_width = $clog2(max_hold + 1);
  localparam logic [cnt_width-1:0] hold_limit = cnt_width'(max_hold);

  logic [cnt_width-1:0] hold_cnt;
  logic                 timeout;
  logic                 owning;
  logic                 other_request;
  logic                 granting;

  assign owning        = (state == ST_HOST) || (state == ST_COP);
  assign other_request = ((state == ST_HOST) && in_cop_request) ||
                         ((state == ST_COP) && in_host_request);
  assign granting      = (state == ST_IDLE) && ((state_next == ST_HOST) || (state_next == ST_COP));

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (granting)                           hold_cnt <= '0;
      else if (owning && hold_cnt != hold_limit) hold_cnt <= hold_cnt + 1'b1;
      if (owning && hold_cnt == hold_limit && other_request) timeout <= 1'b1;
    end
  end

  assign out_timeout = timeout;
`else
  assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - randomized self-checking bench for memory_arbiter
// Compares against an ownership-level model; watchdog expectations follow ARB_WATCHDOG_EN.
module tb_memory_arbiter;
  localparam int W  = 128;
  localparam int AW = 8;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req, cop_req;
  logic          host_grant, cop_grant;
  logic          host_we, host_re, cop_we, cop_re;
  logic [AW-1:0] host_addr, cop_addr;
  logic [W-1:0]  host_data, cop_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          timeout;

  int vectors = 0;
  int miscompares = 0;

  // model: owner 0=none 1=host 2=cop
  int owner, cooldown, last_served, hold;
  bit tmo;

  always #5 clk = ~clk;

  memory_arbiter #(.width(W), .memory_size_log(AW), .max_hold(MH)) dut (
    .in_clk(clk), .in_reset(rst_n),
    .in_host_request(host_req), .out_host_grant(host_grant),
    .in_host_mem_write_en(host_we), .in_host_mem_read_en(host_re),
    .in_host_mem_address(host_addr), .in_host_mem_data(host_data),
    .in_cop_request(cop_req), .out_cop_grant(cop_grant),
    .in_cop_mem_write_en(cop_we), .in_cop_mem_read_en(cop_re),
    .in_cop_mem_address(cop_addr), .in_cop_mem_data(cop_data),
    .out_mem_write_en(mem_we), .out_mem_read_en(mem_re),
    .out_mem_address(mem_addr), .out_mem_data(mem_data),
    .out_timeout(timeout)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; cooldown = 0; last_served = 2; hold = 0; tmo = 0;
  endtask

  // Advance the model by one rising edge using the currently applied requests.
  task automatic model_edge();
    bit other;
    other = (owner == 1) ? cop_req : host_req;
    if (owner != 0) begin
      if (hold == MH && other) tmo = 1;
      if (hold < MH) hold++;
    end
    if (owner == 1 && !host_req) begin
      last_served = 1; owner = 0; cooldown = 1;
    end else if (owner == 2 && !cop_req) begin
      last_served = 2; owner = 0; cooldown = 1;
    end else if (owner == 0) begin
      if (cooldown > 0) cooldown = 0;
      else begin
        if (host_req && cop_req) owner = (last_served == 2) ? 1 : 2;
        else if (host_req)       owner = 1;
        else if (cop_req)        owner = 2;
        if (owner != 0) hold = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic          e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_data;
    bit            e_tmo;
    e_we = 0; e_re = 0; e_addr = '0; e_data = '0;
    if (owner == 1) begin
      e_we = host_we; e_re = host_re; e_addr = host_addr; e_data = host_data;
    end else if (owner == 2) begin
      e_we = cop_we; e_re = cop_re; e_addr = cop_addr; e_data = cop_data;
    end
`ifdef ARB_WATCHDOG_EN
    e_tmo = tmo;
`else
    e_tmo = 0;
`endif
    check("host_grant", W'(host_grant), W'(owner == 1));
    check("cop_grant",  W'(cop_grant),  W'(owner == 2));
    check("mem_we",     W'(mem_we),     W'(e_we));
    check("mem_re",     W'(mem_re),     W'(e_re));
    check("mem_addr",   W'(mem_addr),   W'(e_addr));
    check("mem_data",   mem_data,       e_data);
    check("timeout",    W'(timeout),    W'(e_tmo));
  endtask

  task automatic drive_bus_random();
    host_we   = 1'($urandom); host_re = 1'($urandom);
    cop_we    = 1'($urandom); cop_re  = 1'($urandom);
    host_addr = AW'($urandom); cop_addr = AW'($urandom);
    host_data = {$urandom, $urandom, $urandom, $urandom};
    cop_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; host_req = 0; cop_req = 0;
    host_we = 0; host_re = 0; cop_we = 0; cop_re = 0;
    host_addr = '0; cop_addr = '0; host_data = '0; cop_data = '0;
    model_reset();
    #12;
    host_we = 1; host_addr = 8'h04; host_data = W'(1);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // host write through to the memory port
    host_req = 1;
    step();
    check("host_first_grant", W'(host_grant), W'(1));
    check("host_write_addr", W'(mem_addr), W'(8'h04));
    step();
    host_req = 0;
    step();
    step();
    host_we = 0;

    // simultaneous requests after the host was last served: coprocessor wins
    host_req = 1; cop_req = 1;
    step();
    check("alt_cop_grant", W'(cop_grant), W'(1));

    // async reset during a coprocessor write
    host_req = 0; cop_we = 1; cop_addr = 8'h10; host_we = 1; host_addr = 8'h10;
    guard = 0;
    while (owner != 2 && guard < 10) begin
      step();
      guard++;
    end
    check("cop_owner_reached", W'(owner), W'(2));
    #1 check_outputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_cop_grant", W'(cop_grant), W'(0));
    check("async_mem_we", W'(mem_we), W'(0));
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    host_req = 1; cop_req = 1;
    step();
    check("post_reset_host", W'(host_grant), W'(1));

    // randomized traffic with sticky requests
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) >= 8) host_req = ~host_req;
      if ($urandom_range(0, 9) >= 8) cop_req  = ~cop_req;
      drive_bus_random();
      #1 check_outputs();
      step();
      check("grant_exclusive", W'(host_grant & cop_grant), W'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
